// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: two-port round-robin front end for the SDRAM controller user port, one transaction in flight, read watchdog
module sdram_port_arbiter #(
  parameter int AW = 24,
  parameter int DW = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic          clock0,
  input  logic          reset,
  input  logic          p0_valid,
  input  logic          p0_write,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ready,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_rerr,
  input  logic          p1_valid,
  input  logic          p1_write,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ready,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_rerr,
  output logic          ctl_valid,
  output logic          ctl_write,
  output logic [AW-1:0] ctl_addr,
  output logic [DW-1:0] ctl_wdata,
  input  logic          ctl_ready,
  input  logic          ctl_rvalid,
  input  logic [DW-1:0] ctl_rdata,
  output logic          busy,
  output logic          owner
);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;
  state_t state, state_n;
  logic last, win, accept, ctl_fire, timeout, rd_done;
  logic [WW-1:0] wd;
  always_comb begin
    win = p1_valid & (~p0_valid | ~last);
    p0_ready = (state == IDLE) & p0_valid & ~win;
    p1_ready = (state == IDLE) & p1_valid & win;
    accept = p0_ready | p1_ready;
    ctl_valid = state == ISSUE;
    ctl_fire = ctl_valid & ctl_ready;
    timeout = wd == WW'(TIMEOUT - 1);
    rd_done = (state == WAIT_RD) & (ctl_rvalid | timeout);
    busy = state != IDLE;
    state_n = accept ? ISSUE : ctl_fire ? (ctl_write ? IDLE : WAIT_RD) : rd_done ? IDLE : state;
  end
  always_ff @(posedge clock0)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clock0) begin
    if (reset) begin
      last <= 1'b1;
      owner <= 1'b0;
      ctl_write <= 1'b0;
      ctl_addr <= '0;
      ctl_wdata <= '0;
      wd <= '0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rerr <= 1'b0;
      p1_rerr <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else begin
      p0_rvalid <= rd_done & ~owner;
      p1_rvalid <= rd_done & owner;
      // returned data takes precedence over a coincident timeout
      p0_rerr <= rd_done & ~owner & ~ctl_rvalid;
      p1_rerr <= rd_done & owner & ~ctl_rvalid;
      if (accept) begin
        last <= win;
        owner <= win;
        ctl_write <= win ? p1_write : p0_write;
        ctl_addr <= win ? p1_addr : p0_addr;
        ctl_wdata <= win ? p1_wdata : p0_wdata;
      end
      if (ctl_fire) wd <= '0;
      else if (state == WAIT_RD && wd != WW'(TIMEOUT)) wd <= wd + 1'b1;
      if (rd_done & ~owner) p0_rdata <= ctl_rvalid ? ctl_rdata : '0;
      if (rd_done & owner) p1_rdata <= ctl_rvalid ? ctl_rdata : '0;
    end
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: table-driven arbitration vectors plus scoreboarded read-return sequences
module tb_sdram_port_arbiter;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic p0_valid = 1'b0, p1_valid = 1'b0, p0_write = 1'b0, p1_write = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic p0_ready, p1_ready, p0_rvalid, p1_rvalid, p0_rerr, p1_rerr;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic ctl_valid, ctl_write;
  logic [AW-1:0] ctl_addr;
  logic [DW-1:0] ctl_wdata;
  logic ctl_ready = 1'b1, ctl_rvalid = 1'b0;
  logic [DW-1:0] ctl_rdata = '0;
  logic busy, owner;
  always #5 clk = ~clk;
  sdram_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clock0(clk), .reset(rst),
    .p0_valid(p0_valid), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ready(p0_ready), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_rerr(p0_rerr),
    .p1_valid(p1_valid), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_rerr(p1_rerr),
    .ctl_valid(ctl_valid), .ctl_write(ctl_write), .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata),
    .ctl_ready(ctl_ready), .ctl_rvalid(ctl_rvalid), .ctl_rdata(ctl_rdata),
    .busy(busy), .owner(owner)
  );
  typedef struct {logic [DW-1:0] d; logic e;} ret_t;
  typedef struct {logic v0; logic v1; logic r0; logic r1;} vec_t;
  ret_t q0[$], q1[$];
  int grants[$];
  int n_cmp = 0, n_bad = 0, cnt = 0, ret_delay = 4;
  logic auto_ctl = 1'b0, auto_push = 1'b0;
  logic [AW-1:0] pa = '0;
  vec_t tbl [8];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    logic hs;
    ret_t r;
    #1;
    hs = ctl_valid & ctl_ready & ~ctl_write;
    if (hs) pa = ctl_addr;
    if (p0_valid & p0_ready) begin
      grants.push_back(0);
      if (auto_push && !p0_write) q0.push_back('{d: {8'h0, p0_addr}, e: 1'b0});
    end
    if (p1_valid & p1_ready) begin
      grants.push_back(1);
      if (auto_push && !p1_write) q1.push_back('{d: {8'h0, p1_addr}, e: 1'b0});
    end
    @(posedge clk);
    #1;
    if (p0_rvalid) begin
      if (q0.size() == 0) chk("p0_rvalid_unexpected", p0_rvalid, 1'b0);
      else begin
        r = q0.pop_front();
        chk("p0_rdata", p0_rdata, r.d);
        chk("p0_rerr", p0_rerr, r.e);
      end
    end
    if (p1_rvalid) begin
      if (q1.size() == 0) chk("p1_rvalid_unexpected", p1_rvalid, 1'b0);
      else begin
        r = q1.pop_front();
        chk("p1_rdata", p1_rdata, r.d);
        chk("p1_rerr", p1_rerr, r.e);
      end
    end
    if (auto_ctl) begin
      ctl_rvalid = 1'b0;
      if (hs) cnt = ret_delay;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          ctl_rvalid = 1'b1;
          ctl_rdata = {8'h0, pa};
        end
      end
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    cnt = 0;
    ctl_rvalid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    q0.delete();
    q1.delete();
    grants.delete();
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end
  initial begin
    int n, g;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    #1;
    chk("rst_ready", {p0_ready, p1_ready}, 2'b00);
    chk("rst_rvalid_rerr", {p0_rvalid, p1_rvalid, p0_rerr, p1_rerr}, 4'b0000);
    chk("rst_busy_owner", {busy, owner}, 2'b00);
    chk("rst_ctl", {ctl_valid, ctl_write, ctl_addr, ctl_wdata}, '0);
    chk("rst_rdata", {p0_rdata, p1_rdata}, '0);
    // arbitration table: writes, controller always ready
    p0_write = 1'b1;
    p1_write = 1'b1;
    for (int i = 0; i < 8; i++) begin
      p0_valid = tbl[i].v0;
      p1_valid = tbl[i].v1;
      p0_addr = AW'(24'h000100 + i);
      p1_addr = AW'(24'h200000 + i);
      p0_wdata = 32'hC0DE_0000 + 32'(i);
      p1_wdata = 32'hBEEF_0000 + 32'(i);
      #1;
      chk($sformatf("tbl%0d_ready", i), {p0_ready, p1_ready}, {tbl[i].r0, tbl[i].r1});
      tick();
      p0_valid = 1'b0;
      p1_valid = 1'b0;
      if (tbl[i].r0 | tbl[i].r1) begin
        #1;
        chk($sformatf("tbl%0d_ctl", i), {ctl_valid, ctl_write, ctl_addr, ctl_wdata},
            {1'b1, 1'b1, tbl[i].r1 ? p1_addr : p0_addr, tbl[i].r1 ? p1_wdata : p0_wdata});
        chk($sformatf("tbl%0d_owner", i), owner, tbl[i].r1);
        tick();
        #1;
        chk($sformatf("tbl%0d_idle", i), {busy, ctl_valid}, 2'b00);
      end
    end
    // single p0 write
    p0_addr = 24'h000010;
    p0_wdata = 32'hA5A5_5A5A;
    p0_valid = 1'b1;
    #1;
    chk("w1_ready", {p0_ready, p1_ready}, 2'b10);
    tick();
    p0_valid = 1'b0;
    #1;
    chk("w1_ctl", {ctl_valid, ctl_write, ctl_addr, ctl_wdata, busy}, {1'b1, 1'b1, 24'h000010, 32'hA5A5_5A5A, 1'b1});
    tick();
    #1;
    chk("w1_done", {ctl_valid, busy}, 2'b00);
    // controller stalls 10 cycles in ISSUE
    ctl_ready = 1'b0;
    p0_addr = 24'h003333;
    p0_wdata = 32'h3333_CCCC;
    p0_valid = 1'b1;
    tick();
    p0_addr = 24'h004444;
    p0_wdata = 32'h4444_DDDD;
    p1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("stall%0d_ctl", i), {ctl_valid, ctl_addr, ctl_wdata}, {1'b1, 24'h003333, 32'h3333_CCCC});
      chk($sformatf("stall%0d_ready", i), {p0_ready, p1_ready}, 2'b00);
      tick();
    end
    ctl_ready = 1'b1;
    tick();
    #1;
    chk("stall_done_busy", busy, 1'b0);
    chk("stall_done_tie", {p0_ready, p1_ready}, 2'b01);
    p0_valid = 1'b0;
    p1_valid = 1'b0;
    tick();
    // continuous reads from both ports, controller returns 4 cycles after accept
    do_reset();
    auto_ctl = 1'b1;
    auto_push = 1'b1;
    ret_delay = 4;
    p0_write = 1'b0;
    p1_write = 1'b0;
    p0_addr = 24'h000040;
    p1_addr = 24'h123400;
    n = 0;
    while (grants.size() < 4 && n < 100) begin
      p0_valid = 1'b1;
      p1_valid = 1'b1;
      g = grants.size();
      tick();
      n++;
      if (grants.size() > g) begin
        if (grants[$] == 0) p0_addr++;
        else p1_addr++;
      end
    end
    p0_valid = 1'b0;
    p1_valid = 1'b0;
    n = 0;
    while (q0.size() + q1.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    chk("rr_drained", 32'(q0.size() + q1.size()), 0);
    chk("rr_grants", 32'(grants.size()), 4);
    for (int i = 0; i < grants.size(); i++) chk($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(i % 2));
    // minimum read turnaround
    ret_delay = 1;
    p0_addr = 24'h000077;
    p0_valid = 1'b1;
    tick();
    p0_valid = 1'b0;
    n = 1;
    while (!p0_rvalid && n < 20) begin
      tick();
      n++;
    end
    chk("min_turnaround", 32'(n), 3);
    // read with no return: watchdog completion
    auto_ctl = 1'b0;
    auto_push = 1'b0;
    ctl_rvalid = 1'b0;
    p0_addr = 24'h000055;
    q0.push_back('{d: '0, e: 1'b1});
    p0_valid = 1'b1;
    tick();
    p0_valid = 1'b0;
    tick();
    n = 1;
    while (!p0_rvalid && n < 20) begin
      tick();
      n++;
    end
    chk("timeout_latency", 32'(n), 9);
    chk("timeout_resp", {p0_rerr, p0_rdata}, {1'b1, 32'h0});
    ctl_rvalid = 1'b1;
    ctl_rdata = 32'hDEAD_BEEF;
    tick();
    ctl_rvalid = 1'b0;
    chk("late_return_ignored", {p0_rvalid, p1_rvalid, busy, p0_rdata}, {3'b000, 32'h0});
    // data coincident with the timeout cycle
    p1_addr = 24'h000066;
    ctl_rdata = 32'h1234_5678;
    q1.push_back('{d: 32'h1234_5678, e: 1'b0});
    p1_valid = 1'b1;
    tick();
    p1_valid = 1'b0;
    tick();
    n = 1;
    while (!p1_rvalid && n < 20) begin
      ctl_rvalid = (n == TO);
      tick();
      n++;
    end
    ctl_rvalid = 1'b0;
    chk("coincident_latency", 32'(n), 9);
    chk("coincident_resp", {p1_rerr, p1_rdata}, {1'b0, 32'h1234_5678});
    // reset pulse while waiting for read data
    p0_addr = 24'h000099;
    p0_valid = 1'b1;
    tick();
    p0_valid = 1'b0;
    tick();
    tick();
    chk("pre_reset_busy", busy, 1'b1);
    rst = 1'b1;
    ctl_rvalid = 1'b1;
    ctl_rdata = 32'hFACE_FACE;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_flags", {p0_rvalid, p1_rvalid, p0_rerr, p1_rerr, busy, owner, ctl_valid, ctl_write}, 8'h00);
    chk("mid_rst_ctl", {ctl_addr, ctl_wdata}, '0);
    chk("mid_rst_rdata", {p0_rdata, p1_rdata}, '0);
    tick();
    ctl_rvalid = 1'b0;
    chk("post_rst_no_pulse", {p0_rvalid, p1_rvalid, busy}, 3'b000);
    p0_valid = 1'b1;
    p1_valid = 1'b1;
    #1;
    chk("post_rst_tie", {p0_ready, p1_ready}, 2'b10);
    p0_valid = 1'b0;
    p1_valid = 1'b0;
    tick();
    chk("final_queues_empty", 32'(q0.size() + q1.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
